// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Pipelined RISC-V immediate generator for the decode stage. The immediate is
// extracted from the instruction word and extended to XLEN bits. The format
// comes either from in_imm_sel (AUTO_SEL=0) or from the opcode (AUTO_SEL=1).
// Results sit behind a two-entry valid/ready skid buffer, so decode can stall
// without losing instructions.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_valid      upstream instruction valid
//   in_ready      block can accept this cycle (registered)
//   in_inst       32-bit instruction word
//   in_imm_sel    format select (ignored when AUTO_SEL=1)
//   in_tag        sideband tag, carried through unchanged
//   out_valid     out_* fields valid
//   out_ready     downstream accepts
//   out_imm       extended immediate, XLEN bits
//   out_sel       format actually used
//   out_tag       tag of this instruction
//   out_illegal   AUTO_SEL=1 only: opcode has no immediate format
//
// Format encodings: I=0, S=1, B=2, U=3, J=4, CSR=5; 6 and 7 give imm 0.
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN     = 32,
    parameter bit AUTO_SEL = 1'b0,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_imm_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_sel,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam logic [2:0] IMM_SEL_I   = 3'd0;
    localparam logic [2:0] IMM_SEL_S   = 3'd1;
    localparam logic [2:0] IMM_SEL_B   = 3'd2;
    localparam logic [2:0] IMM_SEL_U   = 3'd3;
    localparam logic [2:0] IMM_SEL_J   = 3'd4;
    localparam logic [2:0] IMM_SEL_CSR = 3'd5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       auto_sel;
    logic             auto_illegal;
    logic [2:0]       fmt_sel;
    logic             fmt_illegal;
    logic [31:0]      imm32;
    logic [XLEN-1:0]  imm_ext;
    logic             accept;
    logic             drain;
    logic             load_out_from_in;
    logic             load_out_from_skid;
    logic             load_skid;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_sel;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_illegal;

    // Opcode decode. SYSTEM instructions with funct3[2] set are the
    // immediate CSR forms; the rest of SYSTEM uses the I layout.
    always_comb begin
        auto_sel     = IMM_SEL_I;
        auto_illegal = 1'b0;
        case (in_inst[6:0])
            7'b0000011,
            7'b0010011,
            7'b1100111: auto_sel = IMM_SEL_I;
            7'b0100011: auto_sel = IMM_SEL_S;
            7'b1100011: auto_sel = IMM_SEL_B;
            7'b1101111: auto_sel = IMM_SEL_J;
            7'b0110111,
            7'b0010111: auto_sel = IMM_SEL_U;
            7'b1110011: auto_sel = in_inst[14] ? IMM_SEL_CSR : IMM_SEL_I;
            default:    auto_illegal = 1'b1;
        endcase
    end

    assign fmt_sel     = AUTO_SEL ? auto_sel : in_imm_sel;
    assign fmt_illegal = AUTO_SEL ? auto_illegal : 1'b0;

    // The immediate is built at 32 bits first. CSR has bit 31 clear, so
    // widening every format by copying bit 31 is correct for all of them.
    always_comb begin
        imm32 = '0;
        if (!fmt_illegal) begin
            case (fmt_sel)
                IMM_SEL_I:   imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                IMM_SEL_S:   imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                IMM_SEL_B:   imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                      in_inst[30:25], in_inst[11:8], 1'b0};
                IMM_SEL_J:   imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                      in_inst[20], in_inst[30:25], in_inst[24:21], 1'b0};
                IMM_SEL_U:   imm32 = {in_inst[31:12], 12'b0};
                IMM_SEL_CSR: imm32 = {27'b0, in_inst[19:15]};
                default:     imm32 = '0;
            endcase
        end
    end

    generate
        if (XLEN == 64) begin : g_xlen64
            assign imm_ext = {{32{imm32[31]}}, imm32};
        end else if (XLEN == 32) begin : g_xlen32
            assign imm_ext = imm32;
        end else begin : g_xlen_bad
            $error("imm_gen_pipe: XLEN must be 32 or 64");
            assign imm_ext = '0;
        end
    endgenerate

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // Next-state and load steering for the two-entry buffer. A new word
    // only lands in SKID when OUT is occupied and not draining this cycle.
    always_comb begin
        state_next         = state;
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next       = ONE;
                    load_out_from_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (accept && drain) begin
                    load_out_from_in = 1'b1;
                end else if (drain) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_next         = ONE;
                    load_out_from_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // State register. in_ready and out_valid are flopped from the next
    // state, so in_ready never depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next != FULL);
            out_valid <= (state_next != EMPTY);
        end
    end

    // Buffer datapath: OUT takes either the fresh result or the skid copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_imm      <= '0;
            out_sel      <= '0;
            out_tag      <= '0;
            out_illegal  <= 1'b0;
            skid_imm     <= '0;
            skid_sel     <= '0;
            skid_tag     <= '0;
            skid_illegal <= 1'b0;
        end else begin
            if (load_out_from_in) begin
                out_imm     <= imm_ext;
                out_sel     <= fmt_sel;
                out_tag     <= in_tag;
                out_illegal <= fmt_illegal;
            end else if (load_out_from_skid) begin
                out_imm     <= skid_imm;
                out_sel     <= skid_sel;
                out_tag     <= skid_tag;
                out_illegal <= skid_illegal;
            end
            if (load_skid) begin
                skid_imm     <= imm_ext;
                skid_sel     <= fmt_sel;
                skid_tag     <= in_tag;
                skid_illegal <= fmt_illegal;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Drives two instances from the same stimulus: dut_a (XLEN=32, opcode-decoded
// format) and dut_b (XLEN=64, format taken from in_imm_sel). A queue models
// the two-entry buffer; immediates come from arithmetic on the bit fields.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

    typedef struct {
        logic [31:0] imm_a;
        logic [2:0]  sel_a;
        logic        ill_a;
        logic [63:0] imm_b;
        logic [2:0]  sel_b;
        logic [4:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [2:0]  in_imm_sel;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_illegal_a;
    logic [31:0] out_imm_a;
    logic [2:0]  out_sel_a;
    logic [4:0]  out_tag_a;
    logic        in_ready_b, out_valid_b, out_illegal_b;
    logic [63:0] out_imm_b;
    logic [2:0]  out_sel_b;
    logic [4:0]  out_tag_b;

    int   checks   = 0;
    int   failures = 0;
    exp_t model_q[$];

    imm_gen_pipe #(.XLEN(32), .AUTO_SEL(1'b1), .TAG_W(5)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_inst(in_inst), .in_imm_sel(in_imm_sel), .in_tag(in_tag),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(out_imm_a),
        .out_sel(out_sel_a), .out_tag(out_tag_a), .out_illegal(out_illegal_a)
    );

    imm_gen_pipe #(.XLEN(64), .AUTO_SEL(1'b0), .TAG_W(5)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_inst(in_inst), .in_imm_sel(in_imm_sel), .in_tag(in_tag),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b),
        .out_sel(out_sel_b), .out_tag(out_tag_b), .out_illegal(out_illegal_b)
    );

    always #5 clk = ~clk;

    // Reference immediate, as a signed value in 64 bits.
    function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] sel);
        longint v;
        v = 0;
        case (sel)
            3'd0: begin
                v = inst[31:20];
                if (inst[31]) v = v - 4096;
            end
            3'd1: begin
                v = inst[31:25] * 32 + inst[11:7];
                if (inst[31]) v = v - 4096;
            end
            3'd2: begin
                v = inst[31] * 4096 + inst[7] * 2048 + inst[30:25] * 32 + inst[11:8] * 2;
                if (inst[31]) v = v - 8192;
            end
            3'd3: begin
                v = longint'(inst[31:12]) * 4096;
                if (inst[31]) v = v - 64'sh1_0000_0000;
            end
            3'd4: begin
                v = inst[31] * 1048576 + inst[19:12] * 4096 + inst[20] * 2048 + inst[30:21] * 2;
                if (inst[31]) v = v - 2097152;
            end
            3'd5: v = inst[19:15];
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic ref_decode(input logic [31:0] inst, output logic [2:0] sel, output logic ill);
        sel = 3'd0;
        ill = 1'b0;
        case (inst[6:0])
            7'h03, 7'h13, 7'h67: sel = 3'd0;
            7'h23:               sel = 3'd1;
            7'h63:               sel = 3'd2;
            7'h6F:               sel = 3'd4;
            7'h37, 7'h17:        sel = 3'd3;
            7'h73:               sel = inst[14] ? 3'd5 : 3'd0;
            default:             ill = 1'b1;
        endcase
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        chk("in_ready_a", {63'b0, in_ready_a}, {63'b0, model_q.size() < 2});
        chk("in_ready_b", {63'b0, in_ready_b}, {63'b0, model_q.size() < 2});
        chk("out_valid_a", {63'b0, out_valid_a}, {63'b0, model_q.size() > 0});
        chk("out_valid_b", {63'b0, out_valid_b}, {63'b0, model_q.size() > 0});
        if (model_q.size() > 0) begin
            e = model_q[0];
            chk("imm_a", {32'b0, out_imm_a}, {32'b0, e.imm_a});
            chk("sel_a", {61'b0, out_sel_a}, {61'b0, e.sel_a});
            chk("ill_a", {63'b0, out_illegal_a}, {63'b0, e.ill_a});
            chk("tag_a", {59'b0, out_tag_a}, {59'b0, e.tag});
            chk("imm_b", out_imm_b, e.imm_b);
            chk("sel_b", {61'b0, out_sel_b}, {61'b0, e.sel_b});
            chk("ill_b", {63'b0, out_illegal_b}, 64'd0);
            chk("tag_b", {59'b0, out_tag_b}, {59'b0, e.tag});
        end
    endtask

    // One clock of stimulus: drive at the falling edge, update the model at
    // the rising edge, then compare the DUT outputs 1 ns later.
    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [2:0] sel,
                                 input logic [4:0] tag, input logic ordy, input logic r);
        exp_t        e;
        logic        acc, drn, ill;
        logic [2:0]  asel;
        logic [63:0] full_a;
        @(negedge clk);
        rst        = r;
        in_valid   = v;
        in_inst    = inst;
        in_imm_sel = sel;
        in_tag     = tag;
        out_ready  = ordy;
        acc = v && !r && (model_q.size() < 2);
        drn = !r && ordy && (model_q.size() > 0);
        ref_decode(inst, asel, ill);
        full_a  = ill ? 64'd0 : ref_imm(inst, asel);
        e.imm_a = full_a[31:0];
        e.sel_a = asel;
        e.ill_a = ill;
        e.imm_b = ref_imm(inst, sel);
        e.sel_b = sel;
        e.tag   = tag;
        @(posedge clk);
        if (r) begin
            model_q.delete();
        end else begin
            if (drn) void'(model_q.pop_front());
            if (acc) model_q.push_back(e);
        end
        #1;
        checkOutput();
    endtask

    task automatic checkResetValues();
        chk("rst_valid_a", {63'b0, out_valid_a}, 64'd0);
        chk("rst_ready_a", {63'b0, in_ready_a}, 64'd1);
        chk("rst_imm_a", {32'b0, out_imm_a}, 64'd0);
        chk("rst_sel_a", {61'b0, out_sel_a}, 64'd0);
        chk("rst_tag_a", {59'b0, out_tag_a}, 64'd0);
        chk("rst_ill_a", {63'b0, out_illegal_a}, 64'd0);
        chk("rst_imm_b", out_imm_b, 64'd0);
        chk("rst_tag_b", {59'b0, out_tag_b}, 64'd0);
    endtask

    initial begin
        logic [6:0]  opcodes [11];
        logic [31:0] rinst;
        opcodes = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h7F, 7'h33};
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_imm_sel = '0; in_tag = '0; out_ready = 1'b0;

        $display("[TB] reset");
        applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hFFF00093, 3'd0, 5'd7, 1'b1, 1'b1);
        checkResetValues();

        $display("[TB] directed formats");
        applyStimulus(1'b1, 32'hFFF00093, 3'd0, 5'd1, 1'b1, 1'b0);
        chk("addi_imm", {32'b0, out_imm_a}, 64'h0000_0000_FFFF_FFFF);
        chk("addi_sel", {61'b0, out_sel_a}, 64'd0);
        applyStimulus(1'b1, 32'hFE000EE3, 3'd2, 5'd2, 1'b1, 1'b0);
        chk("beq_imm", {32'b0, out_imm_a}, 64'h0000_0000_FFFF_FFFC);
        chk("beq_sel", {61'b0, out_sel_a}, 64'd2);
        applyStimulus(1'b1, 32'h123450B7, 3'd3, 5'd3, 1'b1, 1'b0);
        chk("lui_imm", {32'b0, out_imm_a}, 64'h0000_0000_1234_5000);
        applyStimulus(1'b1, 32'h80000037, 3'd3, 5'd4, 1'b1, 1'b0);
        chk("lui64_imm", out_imm_b, 64'hFFFF_FFFF_8000_0000);
        applyStimulus(1'b1, 32'h0002D073, 3'd5, 5'd5, 1'b1, 1'b0);
        chk("csr_imm_b", out_imm_b, 64'd5);
        chk("csr_sel_a", {61'b0, out_sel_a}, 64'd5);
        applyStimulus(1'b1, 32'h0000007F, 3'd0, 5'd6, 1'b1, 1'b0);
        chk("illegal_flag", {63'b0, out_illegal_a}, 64'd1);
        chk("illegal_imm", {32'b0, out_imm_a}, 64'd0);
        applyStimulus(1'b1, 32'h00100093, 3'd0, 5'd7, 1'b1, 1'b0);
        chk("illegal_clear", {63'b0, out_illegal_a}, 64'd0);
        applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);

        $display("[TB] stall and skid");
        applyStimulus(1'b1, 32'h00A00093, 3'd0, 5'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h01400093, 3'd0, 5'd2, 1'b0, 1'b0);
        chk("stall_ready", {63'b0, in_ready_a}, 64'd0);
        chk("stall_tag", {59'b0, out_tag_a}, 64'd1);
        applyStimulus(1'b1, 32'h01E00093, 3'd0, 5'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h01E00093, 3'd0, 5'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h01E00093, 3'd0, 5'd3, 1'b1, 1'b0);
        chk("drain_tag2", {59'b0, out_tag_a}, 64'd2);
        applyStimulus(1'b1, 32'h01E00093, 3'd0, 5'd3, 1'b1, 1'b0);
        chk("drain_tag3", {59'b0, out_tag_a}, 64'd3);
        applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            rinst      = $urandom;
            rinst[6:0] = opcodes[$urandom_range(0, 10)];
            applyStimulus(1'($urandom_range(0, 3) != 0), rinst, 3'($urandom_range(0, 7)),
                          5'($urandom), 1'($urandom_range(0, 2) != 0), 1'b0);
        end

        $display("[TB] reset while full");
        applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h00500013, 3'd0, 5'd21, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00600013, 3'd0, 5'd22, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00700013, 3'd0, 5'd23, 1'b0, 1'b1);
        checkResetValues();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 100; i++) begin
            rinst      = $urandom;
            rinst[6:0] = opcodes[$urandom_range(0, 10)];
            applyStimulus(1'($urandom_range(0, 1)), rinst, 3'($urandom_range(0, 7)),
                          5'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
